// File: rtl/alu_cmp_rs.sv
// alu_cmp_rs: reservation station and oldest-ready issue scheduler for the
// alu_cmp execution unit. Compacting age queue, CDB wakeup with dispatch
// bypass, and an issue lock that holds the presented entry until handshake.

package rv32i_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  rd_tag;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } ooo_instr_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic       is_cmp;
    logic       use_imm;
  } ctrl_word_t;
endpackage

module alu_cmp_rs
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  ooo_instr_t                   disp_instr,
  input  ctrl_word_t                   disp_ctrl,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic                         disp_rs1_rdy,
  input  logic                         disp_rs2_rdy,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output ooo_instr_t                   iss_instr,
  output ctrl_word_t                   iss_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned IW = $clog2(DEPTH);

  // Registered entry state
  logic             valid_q   [DEPTH];
  ooo_instr_t       instr_q   [DEPTH];
  ctrl_word_t       ctrl_q    [DEPTH];
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic             rs1_rdy_q [DEPTH];
  logic             rs2_rdy_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic             lock_q;
  logic [IW-1:0]    lock_idx_q;

  // Entry state after this cycle's CDB wakeup
  ooo_instr_t       instr_w   [DEPTH];
  logic             rs1_rdy_w [DEPTH];
  logic             rs2_rdy_w [DEPTH];

  // Next-state entry arrays
  logic             valid_d   [DEPTH];
  ooo_instr_t       instr_d   [DEPTH];
  ctrl_word_t       ctrl_d    [DEPTH];
  logic [TAG_W-1:0] rs1_tag_d [DEPTH];
  logic [TAG_W-1:0] rs2_tag_d [DEPTH];
  logic             rs1_rdy_d [DEPTH];
  logic             rs2_rdy_d [DEPTH];
  logic [CW-1:0]    count_d;

  logic             cand_found;
  logic [IW-1:0]    cand_idx;
  logic [IW-1:0]    sel;
  logic             issue;
  logic             disp_acc;
  logic [CW-1:0]    cnt_base;
  int unsigned      src;

  ooo_instr_t       new_instr;
  logic             new_rs1_rdy;
  logic             new_rs2_rdy;

  // Oldest entry with both operands ready
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (valid_q[i-1] && rs1_rdy_q[i-1] && rs2_rdy_q[i-1]) begin
        cand_found = 1'b1;
        cand_idx   = IW'(i-1);
      end
    end
  end

  assign sel        = lock_q ? lock_idx_q : cand_idx;
  assign iss_valid  = lock_q || cand_found;
  assign iss_instr  = instr_q[sel];
  assign iss_ctrl   = ctrl_q[sel];
  assign disp_ready = (count_q < CW'(DEPTH));
  assign count      = count_q;

  assign issue    = iss_valid && iss_ready;
  assign disp_acc = disp_valid && disp_ready && !flush;
  assign cnt_base = issue ? (count_q - CW'(1)) : count_q;

  // CDB wakeup of stored entries; rs1 and rs2 match independently
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      instr_w[i]   = instr_q[i];
      rs1_rdy_w[i] = rs1_rdy_q[i];
      rs2_rdy_w[i] = rs2_rdy_q[i];
      if (cdb_valid && valid_q[i] && !rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_tag)) begin
        rs1_rdy_w[i]        = 1'b1;
        instr_w[i].rs1_data = cdb_data;
      end
      if (cdb_valid && valid_q[i] && !rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_tag)) begin
        rs2_rdy_w[i]        = 1'b1;
        instr_w[i].rs2_data = cdb_data;
      end
    end
  end

  // Incoming entry with same-cycle CDB bypass applied
  always_comb begin
    new_instr   = disp_instr;
    new_rs1_rdy = disp_rs1_rdy;
    new_rs2_rdy = disp_rs2_rdy;
    if (!disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_tag)) begin
      new_rs1_rdy        = 1'b1;
      new_instr.rs1_data = cdb_data;
    end
    if (!disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_tag)) begin
      new_rs2_rdy        = 1'b1;
      new_instr.rs2_data = cdb_data;
    end
  end

  // Compaction above the issued slot, then append at the post-issue count
  always_comb begin
    src = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      src = i;
      if (issue && (IW'(i) >= sel) && (i + 1 < DEPTH)) begin
        src = i + 1;
      end
      valid_d[i]   = valid_q[src];
      instr_d[i]   = instr_w[src];
      ctrl_d[i]    = ctrl_q[src];
      rs1_tag_d[i] = rs1_tag_q[src];
      rs2_tag_d[i] = rs2_tag_q[src];
      rs1_rdy_d[i] = rs1_rdy_w[src];
      rs2_rdy_d[i] = rs2_rdy_w[src];
      if (issue && (IW'(i) >= sel) && (i == DEPTH - 1)) begin
        valid_d[i] = 1'b0;
      end
      if (disp_acc && (CW'(i) == cnt_base)) begin
        valid_d[i]   = 1'b1;
        instr_d[i]   = new_instr;
        ctrl_d[i]    = disp_ctrl;
        rs1_tag_d[i] = disp_rs1_tag;
        rs2_tag_d[i] = disp_rs2_tag;
        rs1_rdy_d[i] = new_rs1_rdy;
        rs2_rdy_d[i] = new_rs2_rdy;
      end
      if (flush) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Occupancy: +1 dispatch, -1 issue, cleared by flush
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (disp_acc && !issue) begin
      count_d = count_q + CW'(1);
    end else if (!disp_acc && issue) begin
      count_d = count_q - CW'(1);
    end
  end

  // Entry storage, count and issue lock registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        instr_q[i]   <= '0;
        ctrl_q[i]    <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_rdy_q[i] <= 1'b0;
        rs2_rdy_q[i] <= 1'b0;
      end
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= valid_d[i];
        instr_q[i]   <= instr_d[i];
        ctrl_q[i]    <= ctrl_d[i];
        rs1_tag_q[i] <= rs1_tag_d[i];
        rs2_tag_q[i] <= rs2_tag_d[i];
        rs1_rdy_q[i] <= rs1_rdy_d[i];
        rs2_rdy_q[i] <= rs2_rdy_d[i];
      end
      count_q <= count_d;
      if (flush || issue) begin
        lock_q <= 1'b0;
      end else if (iss_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmp_rs.sv
// Testbench for alu_cmp_rs: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.

module tb_alu_cmp_rs;
  import rv32i_types::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  ooo_instr_t       disp_instr;
  ctrl_word_t       disp_ctrl;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic             disp_rs1_rdy;
  logic             disp_rs2_rdy;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             iss_valid;
  logic             iss_ready;
  ooo_instr_t       iss_instr;
  ctrl_word_t       iss_ctrl;
  logic [2:0]       count;

  alu_cmp_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_instr(disp_instr), .disp_ctrl(disp_ctrl),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_instr(iss_instr), .iss_ctrl(iss_ctrl), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    ooo_instr_t instr;
    ctrl_word_t ctrl;
    logic [5:0] t1;
    logic [5:0] t2;
    bit         r1;
    bit         r2;
  } ment_t;

  ment_t mq[$];
  bit    m_lock;
  int    m_pos;
  int    n_checks;
  int    n_errors;

  // Model: oldest ready instruction, unless one is already being presented
  function automatic int m_sel();
    if (m_lock) return m_pos;
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].r1 && mq[k].r2) return k;
    return -1;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_lock = 0;
    m_pos  = 0;
  endfunction

  // Model: advance one clock edge using the inputs currently driven
  task automatic model_edge();
    int    s;
    bit    iss;
    bit    acc;
    ment_t e;
    s   = m_sel();
    iss = (s >= 0) && iss_ready;
    acc = disp_valid && (mq.size() < DEPTH) && !flush;
    if (cdb_valid) begin
      for (int k = 0; k < mq.size(); k++) begin
        e = mq[k];
        if (!e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.instr.rs1_data = cdb_data; end
        if (!e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.instr.rs2_data = cdb_data; end
        mq[k] = e;
      end
    end
    if (iss) begin
      mq.delete(s);
      m_lock = 0;
    end else if (s >= 0) begin
      m_lock = 1;
      m_pos  = s;
    end
    if (acc) begin
      e.instr = disp_instr;
      e.ctrl  = disp_ctrl;
      e.t1    = disp_rs1_tag;
      e.t2    = disp_rs2_tag;
      e.r1    = disp_rs1_rdy;
      e.r2    = disp_rs2_rdy;
      if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin e.r1 = 1; e.instr.rs1_data = cdb_data; end
      if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin e.r2 = 1; e.instr.rs2_data = cdb_data; end
      mq.push_back(e);
    end
    if (flush) m_reset();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 0;
    disp_valid = 0;
    cdb_valid  = 0;
    iss_ready  = 0;
  endtask

  function automatic ooo_instr_t rnd_instr(logic [31:0] a, logic [31:0] b);
    ooo_instr_t i;
    i.pc       = $urandom;
    i.imm      = $urandom;
    i.rd_tag   = 6'($urandom_range(0, 63));
    i.rs1_data = a;
    i.rs2_data = b;
    return i;
  endfunction

  task automatic drive_disp(input ooo_instr_t ins, input logic [5:0] t1, input bit r1,
                            input logic [5:0] t2, input bit r2);
    logic [31:0] r;
    r = $urandom;
    disp_valid     = 1;
    disp_instr     = ins;
    disp_ctrl.alu_op  = r[3:0];
    disp_ctrl.cmp_op  = r[6:4];
    disp_ctrl.is_cmp  = r[7];
    disp_ctrl.use_imm = r[8];
    disp_rs1_tag   = t1;
    disp_rs1_rdy   = r1;
    disp_rs2_tag   = t2;
    disp_rs2_rdy   = r2;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    m_reset();
    #12;
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    drive_disp(rnd_instr(32'd5, 32'd7), 6'd1, 1, 6'd2, 1);
    iss_ready = 1;
    tick();
    disp_valid = 0;
    n_checks++; if (iss_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid got %b want 1", iss_valid); end
    n_checks++; if (iss_instr.rs1_data !== 32'd5) begin n_errors++; $display("FAIL b2b_rs1 got %h want 5", iss_instr.rs1_data); end
    n_checks++; if (iss_instr.rs2_data !== 32'd7) begin n_errors++; $display("FAIL b2b_rs2 got %h want 7", iss_instr.rs2_data); end
    n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL b2b_count1 got %0d want 1", count); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL b2b_count0 got %0d want 0", count); end
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drained got %b want 0", iss_valid); end
  endtask

  task automatic test_wakeup_order();
    ooo_instr_t a;
    ooo_instr_t b;
    idle_inputs();
    a = rnd_instr(32'h0, 32'h11);
    b = rnd_instr(32'h22, 32'h33);
    drive_disp(a, 6'd3, 0, 6'd4, 1);
    tick();
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL wk_a_blocked got %b want 0", iss_valid); end
    drive_disp(b, 6'd5, 1, 6'd6, 1);
    tick();
    disp_valid = 0;
    n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL wk_count2 got %0d want 2", count); end
    n_checks++; if (iss_valid !== 1'b1 || iss_instr !== b) begin n_errors++; $display("FAIL wk_b_first got %b/%h want 1/%h", iss_valid, iss_instr, b); end
    iss_ready = 1;
    tick();
    n_checks++; if (iss_valid !== 1'b0 || count !== 3'd1) begin n_errors++; $display("FAIL wk_after_b got %b/%0d want 0/1", iss_valid, count); end
    cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'hDEADBEEF;
    tick();
    cdb_valid = 0;
    n_checks++; if (iss_valid !== 1'b1) begin n_errors++; $display("FAIL wk_a_valid got %b want 1", iss_valid); end
    n_checks++; if (iss_instr.rs1_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wk_a_rs1 got %h want deadbeef", iss_instr.rs1_data); end
    n_checks++; if (iss_instr.pc !== a.pc || iss_instr.rs2_data !== 32'h11) begin n_errors++; $display("FAIL wk_a_id got %h/%h want %h/11", iss_instr.pc, iss_instr.rs2_data, a.pc); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL wk_count0 got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    drive_disp(rnd_instr(32'h1, 32'h1111), 6'd8, 1, 6'd9, 0);
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h42;
    tick();
    disp_valid = 0; cdb_valid = 0;
    n_checks++; if (iss_valid !== 1'b1) begin n_errors++; $display("FAIL byp_valid got %b want 1", iss_valid); end
    n_checks++; if (iss_instr.rs2_data !== 32'h42) begin n_errors++; $display("FAIL byp_rs2 got %h want 42", iss_instr.rs2_data); end
    n_checks++; if (iss_instr.rs1_data !== 32'h1) begin n_errors++; $display("FAIL byp_rs1 got %h want 1", iss_instr.rs1_data); end
    iss_ready = 1;
    tick();
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL byp_count got %0d want 0", count); end
  endtask

  task automatic test_full_lock();
    ooo_instr_t e[4];
    int budget;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      e[k] = rnd_instr($urandom, $urandom);
      drive_disp(e[k], 6'd10, 1, 6'd11, 1);
      tick();
    end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL full_count got %0d want 4", count); end
    n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL full_disp_ready got %b want 0", disp_ready); end
    drive_disp(rnd_instr(32'h9, 32'h9), 6'd12, 1, 6'd13, 1);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (iss_valid !== 1'b1 || iss_instr !== e[0]) begin n_errors++; $display("FAIL lock_hold%0d got %b/%h want 1/%h", c, iss_valid, iss_instr, e[0]); end
      tick();
    end
    iss_ready = 1;
    tick();
    iss_ready = 0;
    disp_valid = 0;
    n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL full_issue_count got %0d want 3", count); end
    n_checks++; if (iss_instr !== e[1]) begin n_errors++; $display("FAIL full_next_sel got %h want %h", iss_instr, e[1]); end
    iss_ready = 1;
    budget = 0;
    while (count !== 3'd0 && budget < 10) begin tick(); budget++; end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL full_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      drive_disp(rnd_instr($urandom, $urandom), 6'(40 + k), 0, 6'd50, 1);
      tick();
    end
    n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    drive_disp(rnd_instr(32'h3, 32'h4), 6'd1, 1, 6'd2, 1);
    flush = 1;
    tick();
    flush = 0; disp_valid = 0;
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL flush_iss_valid got %b want 0", iss_valid); end
    tick();
    n_checks++; if (iss_valid !== 1'b0 || count !== 3'd0) begin n_errors++; $display("FAIL flush_dropped got %b/%0d want 0/0", iss_valid, count); end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      drive_disp(rnd_instr($urandom, $urandom), 6'd1, 1, 6'd2, 1);
      tick();
    end
    disp_valid = 0;
    iss_ready  = 1;
    #3;
    rst_n = 0;
    #1;
    m_reset();
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL arst_iss_valid got %b want 0", iss_valid); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL arst_count got %0d want 0", count); end
    n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL arst_disp_ready got %b want 1", disp_ready); end
    #2;
    rst_n = 1;
    iss_ready = 0;
    @(posedge clk);
    #1;
    drive_disp(rnd_instr(32'hA5, 32'h5A), 6'd1, 1, 6'd2, 1);
    iss_ready = 1;
    tick();
    disp_valid = 0;
    n_checks++; if (iss_valid !== 1'b1 || iss_instr.rs1_data !== 32'hA5) begin n_errors++; $display("FAIL arst_redispatch got %b/%h want 1/a5", iss_valid, iss_instr.rs1_data); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL arst_drain got %0d want 0", count); end
  endtask

  task automatic test_random();
    int s;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      disp_valid = 0;
      if ($urandom_range(0, 99) < 55)
        drive_disp(rnd_instr($urandom, $urandom), 6'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
                   6'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6));
      cdb_valid = ($urandom_range(0, 99) < 35);
      cdb_tag   = 6'($urandom_range(0, 7));
      cdb_data  = $urandom;
      iss_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 2);
      s = m_sel();
      n_checks++; if (iss_valid !== (s >= 0)) begin n_errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, iss_valid, (s >= 0)); end
      n_checks++; if (count !== 3'(mq.size())) begin n_errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, mq.size()); end
      n_checks++; if (disp_ready !== (mq.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_disp_ready c%0d got %b want %b", c, disp_ready, (mq.size() < DEPTH)); end
      if (s >= 0) begin
        n_checks++; if (iss_instr !== mq[s].instr) begin n_errors++; $display("FAIL rnd_instr c%0d got %h want %h", c, iss_instr, mq[s].instr); end
        n_checks++; if (iss_ctrl !== mq[s].ctrl) begin n_errors++; $display("FAIL rnd_ctrl c%0d got %h want %h", c, iss_ctrl, mq[s].ctrl); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    disp_instr   = '0;
    disp_ctrl    = '0;
    disp_rs1_tag = '0;
    disp_rs2_tag = '0;
    disp_rs1_rdy = 0;
    disp_rs2_rdy = 0;
    cdb_tag      = '0;
    cdb_data     = '0;
    test_reset();
    test_back_to_back();
    test_wakeup_order();
    test_bypass();
    test_full_lock();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmp_rs.md
# alu_cmp_rs

Reservation station and issue scheduler for the `alu_cmp` execution unit in the out-of-order core. It buffers up to DEPTH dispatched ALU/compare instructions and captures missing source operands from the common data bus (CDB). Each cycle it selects the oldest instruction whose operands are both ready and issues it to `alu_cmp` through a valid/ready handshake. It sits between rename/dispatch and the `alu_cmp` datapath. Instruction payloads use `ooo_instr_t` and `ctrl_word_t` from `rv32i_types`.

## Interface
- DEPTH, 4, number of entries (≥2)
- TAG_W, 6, physical register tag width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; invalidates all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  `count < DEPTH`; no credit for a same-cycle issue
- disp_instr  in  ooo_instr_t  payload; `rs1_data`/`rs2_data` are meaningful only when the matching rdy bit is set
- disp_ctrl  in  ctrl_word_t  control word for `alu_cmp`
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  source tags
- disp_rs1_rdy, disp_rs2_rdy  in  1  operand already valid at dispatch
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  32  broadcast value
- iss_valid  out  1  issue request to `alu_cmp`
- iss_ready  in  1  `alu_cmp` pipeline accepts
- iss_instr  out  ooo_instr_t  payload with both operands filled in
- iss_ctrl  out  ctrl_word_t  control word of the issued entry
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage is a compacting age queue. Entry 0 is the oldest. Valid entries are always contiguous from index 0.
- Each entry holds: valid, instr, ctrl, rs1_tag, rs2_tag, rs1_rdy, rs2_rdy.
- **Dispatch.** On `disp_valid && disp_ready`, write the new entry at index `count` after any compaction caused by a same-cycle issue.
- **Wakeup.** On `cdb_valid`, every valid entry with `!rsX_rdy && rsX_tag == cdb_tag` sets `rsX_rdy`, and `cdb_data` is written into `instr.rsX_data`. rs1 and rs2 are matched independently, so both may wake from one broadcast.
- **Dispatch bypass.** A dispatching entry whose `!disp_rsX_rdy` tag matches a same-cycle CDB broadcast is written with rdy=1 and `cdb_data`.
- **Select.** The candidate is the lowest index with `valid && rs1_rdy && rs2_rdy`. `iss_valid` = a candidate exists, or a lock is held.
- **Lock.** If `iss_valid && !iss_ready`, the selected index is locked. `iss_instr` and `iss_ctrl` stay stable until the handshake, even if an older entry wakes meanwhile. Any dispatch during the lock appends after the locked entry and does not disturb its index.
- **Issue.** On `iss_valid && iss_ready`, remove the selected entry. Entries above it shift down by one and the lock clears.
- **Count update.** `count` +1 on dispatch, -1 on issue, unchanged on both or neither.
- **Flush.** Clears all valid bits, the lock, and `count` next cycle. A dispatch in the same cycle is dropped. A same-cycle issue handshake still completes on the `alu_cmp` side.
- **Reset.** `rst_n` low clears all valid bits, the lock and `count`. Outputs during and after reset: `iss_valid`=0, `count`=0, `disp_ready`=1. `iss_instr`/`iss_ctrl` are don't-care while `iss_valid`=0.

## Timing
- Dispatch-to-issue: 1 cycle minimum. An entry written at edge N with both operands ready drives `iss_valid` in cycle N+1.
- Wakeup-to-issue: 1 cycle. There is no same-cycle CDB-to-issue bypass; the CDB value is visible on `iss_instr` from the cycle after the broadcast edge.
- `iss_*` outputs are combinational from registered state only. No input-to-output combinational path exists except `iss_ready` into next-state logic.
- `disp_ready` depends only on registered `count`.
- Throughput: one issue per cycle when `iss_ready` is held high and ready entries exist.
- Full case: at `count==DEPTH`, `disp_ready`=0 even when an issue occurs in the same cycle.
- Asserting `rst_n` mid-handshake drops all state immediately (asynchronously).

## Test plan
- **Back-to-back with immediate wakeup.** After reset, dispatch with both rdy=1, `rs1_data`=5, `rs2_data`=7, `iss_ready`=1. Expect `iss_valid` the next cycle with operands 5/7; `count` goes 1→0.
- **Wakeup and age order.** Dispatch A (rs1 tag 3 not ready), then B (both ready). B issues first. Then `cdb_valid`, tag 3, data 0xDEADBEEF. A issues one cycle later with `rs1_data`=0xDEADBEEF.
- **Dispatch bypass.** Dispatch with rs2 tag 9 not ready while the same-cycle CDB carries tag 9, data 0x42. Expect issue next cycle with `rs2_data`=0x42.
- **Full and lock.** Fill 4 entries, all ready, with `iss_ready`=0. Expect `disp_ready`=0 and `iss_instr` stable on entry 0 for 3 cycles. Raise `iss_ready` for 1 cycle: `count`=3, and entry 1 is now selected.
- **Flush.** With 3 entries pending, pulse `flush` together with `disp_valid`. Next cycle expect `count`=0, `iss_valid`=0, and the flushed-cycle dispatch absent.
- **Asynchronous reset.** Drop `rst_n` mid-stream between edges. Expect `iss_valid`=0 and `count`=0 immediately; after release, the first dispatch issues normally.
